game_control: RTL and testbench

Top-level sequencing FSM for obstacle_dodger, sitting directly upstream of the sprite datapath. It paces the game at a fixed frame rate. Each frame it draws every sprite for a fixed number of pixel cycles, holds until the frame period expires, erases the same pixels, and then pulses a one-cycle position-update step. It also counts cleared obstacles as the score and freezes the game when the collision input is asserted.

---
 rtl/game_pkg.sv | 18 +
 rtl/game_control_frame_timer.sv | 26 ++
 rtl/game_control.sv | 110 +++++++++++
 tb/tb_game_control.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and default constants for the obstacle_dodger sequencing logic.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRAW   = 3'd1,
      WAIT   = 3'd2,
      ERASE  = 3'd3,
      UPDATE = 3'd4,
      OVER   = 3'd5
   } state_t;

   localparam int SPRITE_PIXELS_DEF = 16;
   localparam int SPRITES_DEF       = 2;
   localparam int FRAME_CYCLES_DEF  = 833334;
   localparam int SCORE_W           = 8;

endpackage

// File: rtl/game_control_frame_timer.sv
// Frame-period counter: cleared on DRAW entry, flags the last cycle of the frame.
module frame_timer #(
   parameter int FRAME_CYCLES = game_pkg::FRAME_CYCLES_DEF
) (
   input  logic clock,
   input  logic resetn,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

   logic [CNT_W-1:0] count_q;

   // Wrap during ERASE is harmless: expire is only consulted in WAIT.
   always_ff @(posedge clock) begin
      if (!resetn)     count_q <= '0;
      else if (clear)  count_q <= '0;
      else if (enable) count_q <= count_q + CNT_W'(1);
   end

   assign expire = (count_q == CNT_LAST);

endmodule

// File: rtl/game_control.sv
// Game sequencer: draw / wait / erase / update per frame, score keeping and freeze on collision.
module game_control
   import game_pkg::*;
#(
   parameter int SPRITE_PIXELS = SPRITE_PIXELS_DEF,
   parameter int SPRITES       = SPRITES_DEF,
   parameter int FRAME_CYCLES  = FRAME_CYCLES_DEF
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               start,
   input  logic               collide,
   input  logic               finish,
   output logic               draw,
   output logic               plot,
   output logic               erase,
   output logic               setoff,
   output logic               step,
   output logic               game_over,
   output logic [SCORE_W-1:0] score,
   output state_t             state_dbg
);

   localparam int N     = SPRITES * SPRITE_PIXELS;
   localparam int PIX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [PIX_W-1:0]   PIX_LAST  = PIX_W'(N - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   state_t             state_q, state_d;
   logic [PIX_W-1:0]   pix_q, pix_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               timer_clear, timer_enable, frame_expire;

   frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame_timer (
      .clock  (clock),
      .resetn (resetn),
      .clear  (timer_clear),
      .enable (timer_enable),
      .expire (frame_expire)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= IDLE;
         pix_q   <= '0;
         score_q <= '0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         score_q <= score_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pix_d       = pix_q;
      score_d     = score_q;
      timer_clear = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = DRAW;
               pix_d       = '0;
               score_d     = '0;
               timer_clear = 1'b1;
            end
         end
         DRAW: begin
            pix_d = pix_q + PIX_W'(1);
            if (pix_q == PIX_LAST) state_d = WAIT;
         end
         WAIT: begin
            // Collision outranks frame expiry so a hit frame is never erased.
            if (collide) begin
               state_d = OVER;
            end else if (frame_expire) begin
               state_d = ERASE;
               pix_d   = '0;
            end
         end
         ERASE: begin
            pix_d = pix_q + PIX_W'(1);
            if (pix_q == PIX_LAST) state_d = UPDATE;
         end
         UPDATE: begin
            if (finish && (score_q != SCORE_MAX)) score_d = score_q + SCORE_W'(1);
            state_d     = DRAW;
            pix_d       = '0;
            timer_clear = 1'b1;
         end
         OVER: begin
            if (start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign timer_enable = (state_q == DRAW) || (state_q == WAIT) ||
                         (state_q == ERASE) || (state_q == UPDATE);

   assign draw      = (state_q == DRAW) || (state_q == ERASE);
   assign plot      = draw;
   assign erase     = (state_q == ERASE);
   assign setoff    = (state_q != IDLE) && (state_q != OVER);
   assign step      = (state_q == UPDATE);
   assign game_over = (state_q == OVER);
   assign score     = score_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control with a short frame (FRAME_CYCLES = 40, N = 32).
module tb_game_control;
   import game_pkg::*;

   localparam int FC = 40;

   logic       clock = 1'b0;
   logic       resetn, start, collide, finish;
   logic       draw, plot, erase, setoff, step, game_over;
   logic [7:0] score;
   state_t     state_dbg;

   int unsigned cyc = 0;
   int unsigned t0;
   int n_checks = 0;
   int n_pass   = 0;

   game_control #(.SPRITE_PIXELS(16), .SPRITES(2), .FRAME_CYCLES(FC)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .start     (start),
      .collide   (collide),
      .finish    (finish),
      .draw      (draw),
      .plot      (plot),
      .erase     (erase),
      .setoff    (setoff),
      .step      (step),
      .game_over (game_over),
      .score     (score),
      .state_dbg (state_dbg)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_state(input state_t s, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (state_dbg == s) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic run_frames(input int n, output int tmo);
      bit ok;
      tmo = 0;
      for (int i = 0; i < n; i++) begin
         wait_state(UPDATE, 200, ok);
         if (!ok) tmo++;
         tick();
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({draw, plot, erase, setoff, step, game_over} !== 6'b0)
         $display("FAIL reset_outputs: got %b want 000000", {draw, plot, erase, setoff, step, game_over});
      else n_pass++;
      n_checks++;
      if (state_dbg !== IDLE || score !== 8'd0)
         $display("FAIL reset_state: state %0d score %0d want IDLE score 0", state_dbg, score);
      else n_pass++;
      resetn = 1'b1;
      tick();
      n_checks++;
      if (state_dbg !== IDLE || setoff !== 1'b0)
         $display("FAIL idle_hold: state %0d setoff %b want IDLE setoff 0", state_dbg, setoff);
      else n_pass++;
   endtask

   task automatic test_start_draw();
      int cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      t0 = cyc;
      n_checks++;
      if (state_dbg !== DRAW || setoff !== 1'b1 || draw !== 1'b1)
         $display("FAIL start_to_draw: state %0d setoff %b draw %b want DRAW 1 1", state_dbg, setoff, draw);
      else n_pass++;
      cnt = 0;
      while (draw === 1'b1 && plot === 1'b1 && erase === 1'b0 && cnt < 100) begin
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt !== 32) $display("FAIL draw_length: got %0d cycles want 32", cnt);
      else n_pass++;
      n_checks++;
      if (state_dbg !== WAIT || draw !== 1'b0 || setoff !== 1'b1)
         $display("FAIL enter_wait: state %0d draw %b setoff %b want WAIT 0 1", state_dbg, draw, setoff);
      else n_pass++;
   endtask

   task automatic test_full_frame();
      int cnt;
      cnt = 0;
      while (state_dbg == WAIT && cnt < 100) begin
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt !== 8) $display("FAIL wait_length: got %0d cycles want 8", cnt);
      else n_pass++;
      cnt = 0;
      while (erase === 1'b1 && draw === 1'b1 && plot === 1'b1 && cnt < 100) begin
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt !== 32) $display("FAIL erase_length: got %0d cycles want 32", cnt);
      else n_pass++;
      n_checks++;
      if (state_dbg !== UPDATE || step !== 1'b1 || draw !== 1'b0)
         $display("FAIL update_step: state %0d step %b draw %b want UPDATE 1 0", state_dbg, step, draw);
      else n_pass++;
      tick();
      n_checks++;
      if (state_dbg !== DRAW || step !== 1'b0 || draw !== 1'b1)
         $display("FAIL next_draw: state %0d step %b draw %b want DRAW 0 1", state_dbg, step, draw);
      else n_pass++;
      n_checks++;
      if (cyc - t0 !== 73) $display("FAIL frame_period: got %0d cycles want 73", cyc - t0);
      else n_pass++;
      n_checks++;
      if (score !== 8'd0) $display("FAIL score_no_finish: got %0d want 0", score);
      else n_pass++;
   endtask

   task automatic test_scoring();
      int tmo;
      finish = 1'b1;
      run_frames(3, tmo);
      n_checks++;
      if (tmo !== 0 || score !== 8'd3) $display("FAIL score_3: got %0d (timeouts %0d) want 3", score, tmo);
      else n_pass++;
      run_frames(251, tmo);
      n_checks++;
      if (tmo !== 0 || score !== 8'd254) $display("FAIL score_254: got %0d (timeouts %0d) want 254", score, tmo);
      else n_pass++;
      run_frames(2, tmo);
      n_checks++;
      if (tmo !== 0 || score !== 8'd255) $display("FAIL score_saturate: got %0d (timeouts %0d) want 255", score, tmo);
      else n_pass++;
      finish = 1'b0;
   endtask

   task automatic test_collision();
      bit ok;
      bit saw_bad;
      wait_state(WAIT, 100, ok);
      n_checks++;
      if (!ok) $display("FAIL reach_wait: timed out, state %0d want WAIT", state_dbg);
      else n_pass++;
      collide = 1'b1;
      tick();
      collide = 1'b0;
      n_checks++;
      if (state_dbg !== OVER || game_over !== 1'b1)
         $display("FAIL collide_over: state %0d game_over %b want OVER 1", state_dbg, game_over);
      else n_pass++;
      n_checks++;
      if ({draw, plot, erase, step, setoff} !== 5'b0 || score !== 8'd255)
         $display("FAIL over_outputs: strobes %b score %0d want 00000 255", {draw, plot, erase, step, setoff}, score);
      else n_pass++;
      saw_bad = 1'b0;
      repeat (5) begin
         tick();
         if (erase !== 1'b0 || step !== 1'b0 || state_dbg !== OVER) saw_bad = 1'b1;
      end
      n_checks++;
      if (saw_bad) $display("FAIL over_hold: state %0d left OVER or strobed, want OVER", state_dbg);
      else n_pass++;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (state_dbg !== IDLE || score !== 8'd255 || game_over !== 1'b0)
         $display("FAIL over_to_idle: state %0d score %0d game_over %b want IDLE 255 0", state_dbg, score, game_over);
      else n_pass++;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (state_dbg !== DRAW || score !== 8'd0 || draw !== 1'b1)
         $display("FAIL restart: state %0d score %0d draw %b want DRAW 0 1", state_dbg, score, draw);
      else n_pass++;
   endtask

   task automatic test_ignored_collision();
      bit saw_over;
      bit reached;
      saw_over = 1'b0;
      reached  = 1'b0;
      finish   = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (state_dbg == OVER) saw_over = 1'b1;
         if (state_dbg == UPDATE) begin
            reached = 1'b1;
            break;
         end
         collide = (state_dbg == DRAW) || (state_dbg == ERASE);
         tick();
      end
      collide = 1'b0;
      n_checks++;
      if (!reached || saw_over)
         $display("FAIL ignored_collide: reached_update %b saw_over %b want 1 0", reached, saw_over);
      else n_pass++;
      tick();
      finish = 1'b0;
      n_checks++;
      if (state_dbg !== DRAW || score !== 8'd1)
         $display("FAIL ignored_collide_frame: state %0d score %0d want DRAW 1", state_dbg, score);
      else n_pass++;
   endtask

   task automatic test_reset_mid_erase();
      bit ok;
      wait_state(ERASE, 200, ok);
      n_checks++;
      if (!ok) $display("FAIL reach_erase: timed out, state %0d want ERASE", state_dbg);
      else n_pass++;
      repeat (10) tick();
      n_checks++;
      if (state_dbg !== ERASE || erase !== 1'b1)
         $display("FAIL erase_pix10: state %0d erase %b want ERASE 1", state_dbg, erase);
      else n_pass++;
      resetn = 1'b0;
      tick();
      n_checks++;
      if ({draw, plot, erase, setoff, step, game_over} !== 6'b0 || state_dbg !== IDLE || score !== 8'd0)
         $display("FAIL reset_mid_erase: outs %b state %0d score %0d want 000000 IDLE 0",
                  {draw, plot, erase, setoff, step, game_over}, state_dbg, score);
      else n_pass++;
      resetn = 1'b1;
      tick();
      n_checks++;
      if (state_dbg !== IDLE || draw !== 1'b0)
         $display("FAIL post_reset_idle: state %0d draw %b want IDLE 0", state_dbg, draw);
      else n_pass++;
   endtask

   initial begin
      resetn  = 1'b0;
      start   = 1'b0;
      collide = 1'b0;
      finish  = 1'b0;
      test_reset();
      test_start_draw();
      test_full_frame();
      test_scoring();
      test_collision();
      test_ignored_collision();
      test_reset_mid_erase();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
